// File: rtl/duck_hunt_pkg.sv
// Shared Duck Hunt constants: FSM state encoding, screen bounds, palette.
package duck_hunt_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int MAX_BIRDS = 8;

    localparam logic [2:0] COL_BG   = 3'b000;
    localparam logic [2:0] COL_BIRD = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ERASE_START,
        ERASE_WAIT,
        UPDATE,
        SETTLE,
        DRAW_START,
        DRAW_WAIT
    } seq_state_t;

    function automatic logic on_screen(input logic [7:0] x, input logic [6:0] y);
        return (x < 8'(SCREEN_W)) && (y < 7'(SCREEN_H));
    endfunction

endpackage

// File: rtl/bird_pos_store.sv
// Per-slot record of where each bird was last drawn; write/set/clear take effect next cycle,
// read is combinational on idx.
module bird_pos_store
    import duck_hunt_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] idx,
    input  logic       wr_en,
    input  logic [7:0] wr_x,
    input  logic [6:0] wr_y,
    input  logic       set_en,
    input  logic       clr_en,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    output logic       rd_drawn
);

    logic [7:0]           saved_x [MAX_BIRDS];
    logic [6:0]           saved_y [MAX_BIRDS];
    logic [MAX_BIRDS-1:0] drawn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_BIRDS; i++) begin
                saved_x[i] <= '0;
                saved_y[i] <= '0;
            end
            drawn <= '0;
        end else begin
            if (wr_en) begin
                saved_x[idx] <= wr_x;
                saved_y[idx] <= wr_y;
            end
            if (set_en)
                drawn[idx] <= 1'b1;
            else if (clr_en)
                drawn[idx] <= 1'b0;
        end
    end

    assign rd_x     = saved_x[idx];
    assign rd_y     = saved_y[idx];
    assign rd_drawn = drawn[idx];

endmodule

// File: rtl/bird_frame_sequencer.sv
// Per frame: erase every drawn bird, pulse pos_update, then draw every live bird via the shared
// sprite engine; frame_tick while busy is dropped and flagged as frame_overrun.
module bird_frame_sequencer
    import duck_hunt_pkg::*;
#(
    parameter int         NUM_BIRDS   = 4,
    parameter logic [2:0] BG_COLOUR   = COL_BG,
    parameter logic [2:0] BIRD_COLOUR = COL_BIRD
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_tick,
    input  logic [8*NUM_BIRDS-1:0] bird_x,
    input  logic [7*NUM_BIRDS-1:0] bird_y,
    input  logic [NUM_BIRDS-1:0]   bird_alive,
    input  logic [7:0]             spr_x,
    input  logic [6:0]             spr_y,
    input  logic                   spr_valid,
    input  logic                   spr_done,
    output logic                   spr_start,
    output logic [7:0]             spr_base_x,
    output logic [6:0]             spr_base_y,
    output logic                   pos_update,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   frame_overrun
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_BIRDS - 1);

    seq_state_t           state;
    logic [2:0]           idx;
    logic                 last_slot;
    logic [7:0]           cur_x [MAX_BIRDS];
    logic [6:0]           cur_y [MAX_BIRDS];
    logic [MAX_BIRDS-1:0] alive;
    logic [7:0]           rd_x;
    logic [6:0]           rd_y;
    logic                 rd_drawn;
    logic                 wr_en;

    // Unused slots read as dead at (0,0) so a 3-bit idx always lands on a defined entry.
    for (genvar i = 0; i < MAX_BIRDS; i++) begin : g_slot
        if (i < NUM_BIRDS) begin : g_used
            assign cur_x[i] = bird_x[8*i +: 8];
            assign cur_y[i] = bird_y[7*i +: 7];
            assign alive[i] = bird_alive[i];
        end else begin : g_unused
            assign cur_x[i] = '0;
            assign cur_y[i] = '0;
            assign alive[i] = 1'b0;
        end
    end

    assign last_slot = (idx == LAST_IDX);
    assign wr_en     = (state == DRAW_START) && alive[idx];

    bird_pos_store u_store (
        .clock    (clock),
        .reset    (reset),
        .idx      (idx),
        .wr_en    (wr_en),
        .wr_x     (cur_x[idx]),
        .wr_y     (cur_y[idx]),
        .set_en   ((state == DRAW_WAIT) && spr_done),
        .clr_en   ((state == ERASE_WAIT) && spr_done),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_drawn (rd_drawn)
    );

    // spr_done is only sampled in the WAIT states: the engine still reports idle while start is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= '0;
            frame_overrun <= 1'b0;
        end else begin
            frame_overrun <= frame_tick && (state != IDLE);
            case (state)
                IDLE: if (frame_tick) begin
                    state <= ERASE_START;
                    idx   <= '0;
                end
                ERASE_START: begin
                    if (rd_drawn) begin
                        state <= ERASE_WAIT;
                    end else if (last_slot) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ERASE_WAIT: if (spr_done) begin
                    if (last_slot) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end else begin
                        state <= ERASE_START;
                        idx   <= idx + 3'd1;
                    end
                end
                UPDATE: state <= SETTLE;
                SETTLE: begin
                    state <= DRAW_START;
                    idx   <= '0;
                end
                DRAW_START: begin
                    if (alive[idx]) begin
                        state <= DRAW_WAIT;
                    end else if (last_slot) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DRAW_WAIT: if (spr_done) begin
                    if (last_slot) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        state <= DRAW_START;
                        idx   <= idx + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Draw launches use the live position; once captured, the stored copy holds the anchor steady.
    always_comb begin
        spr_base_x = '0;
        spr_base_y = '0;
        case (state)
            ERASE_START, ERASE_WAIT, DRAW_WAIT: begin
                spr_base_x = rd_x;
                spr_base_y = rd_y;
            end
            DRAW_START: begin
                spr_base_x = cur_x[idx];
                spr_base_y = cur_y[idx];
            end
            default: ;
        endcase
    end

    assign spr_start  = ((state == ERASE_START) && rd_drawn) || wr_en;
    assign pos_update = (state == UPDATE);
    assign busy       = (state != IDLE);
    assign vga_x      = spr_x;
    assign vga_y      = spr_y;
    assign vga_colour = (state == DRAW_WAIT) ? BIRD_COLOUR : BG_COLOUR;
    assign vga_plot   = spr_valid && ((state == ERASE_WAIT) || (state == DRAW_WAIT))
                        && on_screen(spr_x, spr_y);

endmodule

// File: tb/tb_bird_frame_sequencer.sv
// Directed bench: table of frames with hand-computed launch/plot/busy counts plus reset corner cases.
module tb_bird_frame_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic [31:0] bird_x;
    logic [27:0] bird_y;
    logic [3:0]  bird_alive;
    logic [7:0]  spr_x;
    logic [6:0]  spr_y;
    logic        spr_valid;
    logic        spr_done;
    logic        spr_start;
    logic [7:0]  spr_base_x;
    logic [6:0]  spr_base_y;
    logic        pos_update;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        busy;
    logic        frame_overrun;

    bird_frame_sequencer #(.NUM_BIRDS(4), .BG_COLOUR(3'b000), .BIRD_COLOUR(3'b111)) dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick),
        .bird_x(bird_x), .bird_y(bird_y), .bird_alive(bird_alive),
        .spr_x(spr_x), .spr_y(spr_y), .spr_valid(spr_valid), .spr_done(spr_done),
        .spr_start(spr_start), .spr_base_x(spr_base_x), .spr_base_y(spr_base_y),
        .pos_update(pos_update), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .frame_overrun(frame_overrun)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Observer: everything sampled on the falling edge, half a cycle from the active edge.
    int n_start = 0, n_upd = 0, n_bg = 0, n_bird = 0, n_busy = 0, n_ovr = 0, n_off = 0, n_pass_err = 0;
    bit upd_phase = 1'b0;
    int lq_xy[$];
    bit lq_ph[$];

    always @(negedge clock) begin
        if (!busy) upd_phase = 1'b0;
        if (pos_update) begin
            n_upd++;
            upd_phase = 1'b1;
        end
        if (spr_start) begin
            n_start++;
            lq_xy.push_back(int'(spr_base_x) * 256 + int'(spr_base_y));
            lq_ph.push_back(upd_phase);
        end
        if (vga_plot && vga_colour == 3'b000) n_bg++;
        if (vga_plot && vga_colour == 3'b111) n_bird++;
        if (vga_plot && (spr_x >= 8'd160 || spr_y >= 7'd120)) n_off++;
        if (busy) n_busy++;
        if (frame_overrun) n_ovr++;
        if (vga_x !== spr_x || vga_y !== spr_y) n_pass_err++;
    end

    // Sprite engine model: after each launch, drop done, emit npix pixels, then raise done.
    int npix = 1;
    bit offmode = 1'b0;
    int eng_seen = 0;
    int cnt = 0;
    int k = 0;
    logic [7:0] ex;
    logic [6:0] ey;

    initial begin
        spr_done = 1'b1; spr_valid = 1'b0; spr_x = '0; spr_y = '0;
        ex = '0; ey = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                spr_done = 1'b1; spr_valid = 1'b0; cnt = 0; eng_seen = n_start;
            end else begin
                if (n_start != eng_seen) begin
                    eng_seen = n_start; spr_done = 1'b0; cnt = npix; k = 0;
                    ex = spr_base_x; ey = spr_base_y;
                end
                if (!spr_done) begin
                    if (cnt > 0) begin
                        spr_valid = 1'b1;
                        if (offmode) begin
                            case (k)
                                0: begin spr_x = 8'hFF; spr_y = 7'h7F; end
                                1: begin spr_x = 8'd160; spr_y = 7'd5; end
                                2: begin spr_x = 8'd159; spr_y = 7'd119; end
                                3: begin spr_x = 8'd100; spr_y = 7'd120; end
                                default: begin spr_x = 8'd10; spr_y = 7'd10; end
                            endcase
                        end else begin
                            spr_x = ex + 8'(k); spr_y = ey;
                        end
                        k++; cnt--;
                    end else begin
                        spr_valid = 1'b0; spr_done = 1'b1;
                    end
                end
            end
        end
    end

    // Expected stored anchors and drawn flags.
    bit m_drawn[4];
    int m_x[4], m_y[4];

    typedef struct {
        logic [3:0] alive;
        int npix;
        int mode;   // 0 normal, 1 tick mid draw, 2 tick on final cycle, 3 off-screen pixels
        int e;
        int d;
        int bg;
        int bird;
        int bsy;
        int ovr;
    } vec_t;

    function automatic int pos_x(input int i, input int f); return 10 + 20 * i + 3 * f; endfunction
    function automatic int pos_y(input int i, input int f); return 5 + 10 * i + f; endfunction

    task automatic run_frame(input vec_t v, input int f);
        int exy[$];
        int s_upd, s_bg, s_bird, s_busy, s_ovr, q0, ne, nd;
        bit fired, done_ok;
        for (int i = 0; i < 4; i++) begin
            bird_x[8*i +: 8] = 8'(pos_x(i, f));
            bird_y[7*i +: 7] = 7'(pos_y(i, f));
        end
        bird_alive = v.alive; npix = v.npix; offmode = (v.mode == 3);
        for (int i = 0; i < 4; i++)
            if (m_drawn[i]) begin exy.push_back(m_x[i] * 256 + m_y[i]); m_drawn[i] = 1'b0; end
        for (int i = 0; i < 4; i++)
            if (v.alive[i]) begin
                m_x[i] = pos_x(i, f); m_y[i] = pos_y(i, f); m_drawn[i] = 1'b1;
                exy.push_back(m_x[i] * 256 + m_y[i]);
            end
        s_upd = n_upd; s_bg = n_bg; s_bird = n_bird; s_busy = n_busy; s_ovr = n_ovr;
        q0 = lq_xy.size();
        @(negedge clock); frame_tick = 1'b1;
        fired = 1'b0; done_ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            if (!busy) begin done_ok = 1'b1; break; end
            if (!fired && ((v.mode == 1 && vga_colour == 3'b111) ||
                           (v.mode == 2 && vga_colour == 3'b111 && spr_done))) begin
                frame_tick = 1'b1; fired = 1'b1;
            end
        end
        chk($sformatf("f%0d_frame_end", f), int'(done_ok), 1);
        repeat (20) @(negedge clock);
        ne = 0; nd = 0;
        for (int j = q0; j < lq_xy.size(); j++) if (lq_ph[j]) nd++; else ne++;
        chk($sformatf("f%0d_erase_launches", f), ne, v.e);
        chk($sformatf("f%0d_draw_launches", f), nd, v.d);
        chk($sformatf("f%0d_pos_update", f), n_upd - s_upd, 1);
        chk($sformatf("f%0d_bg_plots", f), n_bg - s_bg, v.bg);
        chk($sformatf("f%0d_bird_plots", f), n_bird - s_bird, v.bird);
        chk($sformatf("f%0d_busy_cycles", f), n_busy - s_busy, v.bsy);
        chk($sformatf("f%0d_overrun", f), n_ovr - s_ovr, v.ovr);
        chk($sformatf("f%0d_idle_after", f), int'(busy), 0);
        for (int j = 0; j < exy.size() && q0 + j < lq_xy.size(); j++)
            chk($sformatf("f%0d_launch%0d_xy", f, j), lq_xy[q0 + j], exy[j]);
    endtask

    vec_t vt[8];
    vec_t vpost;

    initial begin
        int s_upd, s_start, s_busy;
        bit found;
        vt[0] = '{4'b0101, 13, 0, 0, 2, 0, 26, 38, 0};
        vt[1] = '{4'b1111,  3, 0, 2, 4, 6, 12, 34, 0};
        vt[2] = '{4'b0000,  5, 0, 4, 0, 20, 0, 34, 0};
        vt[3] = '{4'b0000,  2, 0, 0, 0, 0, 0, 10, 0};
        vt[4] = '{4'b1000,  1, 0, 0, 1, 0, 1, 12, 0};
        vt[5] = '{4'b0011,  4, 3, 1, 2, 1, 2, 25, 0};
        vt[6] = '{4'b0010,  6, 1, 2, 1, 12, 6, 31, 1};
        vt[7] = '{4'b1000,  2, 2, 1, 1, 2, 2, 16, 1};
        vpost = '{4'b0000,  2, 0, 0, 0, 0, 0, 10, 0};
        for (int i = 0; i < 4; i++) begin m_drawn[i] = 1'b0; m_x[i] = 0; m_y[i] = 0; end

        reset = 1'b1; frame_tick = 1'b0; bird_x = '0; bird_y = '0; bird_alive = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_spr_start", int'(spr_start), 0);
        chk("rst_pos_update", int'(pos_update), 0);
        chk("rst_vga_plot", int'(vga_plot), 0);
        chk("rst_vga_colour", int'(vga_colour), 0);
        chk("rst_overrun", int'(frame_overrun), 0);
        chk("rst_base", int'(spr_base_x) + int'(spr_base_y), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("idle_busy", int'(busy), 0);

        for (int f = 0; f < 8; f++) run_frame(vt[f], f);

        // Abort a frame from inside ERASE_WAIT (slot 3 is still drawn from the previous frame).
        bird_alive = 4'b0000; npix = 20; offmode = 1'b0;
        @(negedge clock); frame_tick = 1'b1;
        @(negedge clock); frame_tick = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (busy && !upd_phase && !spr_done) begin found = 1'b1; break; end
            @(negedge clock);
        end
        chk("erase_wait_reached", int'(found), 1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_spr_start", int'(spr_start), 0);
        @(negedge clock); reset = 1'b0;
        for (int i = 0; i < 4; i++) m_drawn[i] = 1'b0;
        s_upd = n_upd; s_start = n_start; s_busy = n_busy;
        repeat (20) @(negedge clock);
        chk("postrst_pos_update", n_upd - s_upd, 0);
        chk("postrst_spr_start", n_start - s_start, 0);
        chk("postrst_busy_cycles", n_busy - s_busy, 0);
        run_frame(vpost, 8);

        chk("offscreen_plots", n_off, 0);
        chk("vga_passthrough_errors", n_pass_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
